// File: rtl/seq_sched_if.sv
// Purpose: request/stream bundle between seq_sched and its requesters/consumer.
// Ports (master = scheduler side):
//   req       requester level requests          (scheduler input)
//   len       packed per-requester burst length (scheduler input)
//   seq_ready consumer ready                    (scheduler input)
//   grant     one-hot stream owner              (scheduler output)
//   busy      burst in progress                 (scheduler output)
//   seq_valid / seq_data / seq_last  stream beat (scheduler output)
//   done / done_id  end-of-burst pulse + owner  (scheduler output)
interface seq_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     seq_valid;
  logic                     seq_ready;
  logic [2:0]               seq_data;
  logic                     seq_last;
  logic                     done;
  logic [ID_W-1:0]          done_id;

  modport master (
    input  req, len, seq_ready,
    output grant, busy, seq_valid, seq_data, seq_last, done, done_id
  );

  modport slave (
    output req, len, seq_ready,
    input  grant, busy, seq_valid, seq_data, seq_last, done, done_id
  );
endinterface

// File: rtl/seq_sched.sv
// Purpose: round-robin scheduler granting bursts of a 4-step sequence
//   (000 -> 010 -> 011 -> 101 -> wrap) to NUM_REQ requesters.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  seq_sched_if master modport (requests, lengths, stream, done)
module seq_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ID_W    = 2,
  parameter bit          RESTART = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  seq_sched_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [1:0]         step_q, step_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic [2:0]         data_q, data_d;

  logic [NUM_REQ-1:0] elig_c;
  logic               hi_found_c, lo_found_c, found_c;
  logic [ID_W-1:0]    hi_win_c, lo_win_c, win_c;
  logic [CNT_W-1:0]   hi_len_c, lo_len_c, win_len_c;

  // Sequence value for a step pointer.
  function automatic logic [2:0] step_val(input logic [1:0] s);
    logic [2:0] v;
    case (s)
      2'd0:    v = 3'b000;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b011;
      default: v = 3'b101;
    endcase
    return v;
  endfunction

  // Round-robin pick: lowest eligible index at/above rr_q, else lowest overall.
  // Descending scan so the final assignment holds the smallest index.
  always_comb begin
    elig_c     = '0;
    hi_found_c = 1'b0;
    lo_found_c = 1'b0;
    hi_win_c   = '0;
    lo_win_c   = '0;
    hi_len_c   = '0;
    lo_len_c   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      elig_c[i] = bus.req[i] & (|bus.len[i*CNT_W +: CNT_W]);
      if (elig_c[i]) begin
        if (ID_W'(i) >= rr_q) begin
          hi_found_c = 1'b1;
          hi_win_c   = ID_W'(i);
          hi_len_c   = bus.len[i*CNT_W +: CNT_W];
        end
        lo_found_c = 1'b1;
        lo_win_c   = ID_W'(i);
        lo_len_c   = bus.len[i*CNT_W +: CNT_W];
      end
    end
    found_c   = hi_found_c | lo_found_c;
    win_c     = hi_found_c ? hi_win_c : lo_win_c;
    win_len_c = hi_found_c ? hi_len_c : lo_len_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rem_d     = rem_q;
    step_d    = step_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = BURST;
          grant_d = NUM_REQ'(1) << win_c;
          rem_d   = win_len_c;
          owner_d = win_c;
          rr_d    = (win_c == ID_W'(NUM_REQ - 1)) ? '0 : win_c + ID_W'(1);
          if (RESTART) step_d = 2'd0;
          valid_d = 1'b1;
          data_d  = step_val(step_d);
          last_d  = (win_len_c == CNT_W'(1));
        end
      end
      BURST: begin
        if (valid_q && bus.seq_ready) begin
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          step_d = step_q + 2'd1;
          if (last_q) begin
            state_d   = IDLE;
            grant_d   = '0;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            data_d    = 3'b000;
            done_d    = 1'b1;
            done_id_d = owner_q;
          end else begin
            data_d = step_val(step_d);
            last_d = (rem_d == CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset also aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rem_q     <= '0;
      step_q    <= 2'd0;
      rr_q      <= '0;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= 3'b000;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = valid_q;
  assign bus.seq_valid = valid_q;
  assign bus.seq_data  = data_q;
  assign bus.seq_last  = last_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;

endmodule

// File: doc/seq_sched.md
Name: seq_sched

Overview:
Round-robin scheduler that shares one 4-step sequence source among NUM_REQ requesters. Each granted requester receives a burst of LEN sequence values over a valid/ready stream. The 4-step sequence is 3'b000 -> 3'b010 -> 3'b011 -> 3'b101, then wraps to 3'b000; the step pointer is held internally. The block sits between the sequence source and its consumers and decides who owns the stream and for how many beats.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 8, width of burst length field and remaining-beat counter
ID_W, 2, width of requester index; 2**ID_W >= NUM_REQ
RESTART, 0, 1 = every burst starts at step S0; 0 = step pointer continues across bursts

Ports:
clk  in  1  rising-edge clock, single clock domain
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
req  in  NUM_REQ  request per requester, level
len  in  NUM_REQ*CNT_W  burst length per requester; requester i uses bits [i*CNT_W +: CNT_W]
grant  out  NUM_REQ  one-hot owner of the stream, registered
busy  out  1  high while in BURST
seq_valid  out  1  stream valid
seq_ready  in  1  stream ready from consumer
seq_data  out  3  current sequence value
seq_last  out  1  high with the final beat of a burst
done  out  1  one-cycle pulse after the last beat of a burst is accepted
done_id  out  ID_W  index of the requester whose burst finished; valid with done

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; grant=0; busy=0; seq_valid=0; seq_last=0; seq_data=3'b000; done=0; done_id=0; step pointer=S0; round-robin pointer=0; remaining count=0. Reset mid-burst aborts the burst immediately. No done is issued for an aborted burst.
- Eligibility: requester i is eligible when req[i]=1 and its len field is nonzero. A requester with len=0 is never granted.
- FSM states: IDLE and BURST.
- IDLE: if any requester is eligible, pick the first eligible index searching upward (with wrap) from the round-robin pointer. At the next posedge:
  - grant=onehot(winner); busy=1; state=BURST.
  - remaining=len[winner], latched at this point; later len changes are ignored.
  - round-robin pointer=(winner+1) mod NUM_REQ.
  - if RESTART=1, step pointer=S0.
  - If no requester is eligible, stay in IDLE with all outputs idle.
- BURST:
  - seq_valid=1; seq_data=value(step pointer); seq_last=(remaining==1).
  - Beat accepted when seq_valid & seq_ready: step pointer advances S0->S1->S2->S3->S0 and remaining decrements.
  - While seq_valid & !seq_ready: seq_data and seq_last hold stable.
  - req deassertion during a burst is ignored; the burst runs to completion.
  - Accepting the beat with seq_last=1 moves the FSM to IDLE at that posedge: grant=0, busy=0, seq_valid=0, seq_last=0, done=1, done_id=winner index.
  - done returns to 0 on the following cycle.
- Latency:
  - First beat is valid 1 cycle after the request is seen in IDLE.
  - Between bursts there is at least 1 IDLE cycle, so a new grant appears 2 cycles after the previous last-beat acceptance.
- Step values: S0=3'b000, S1=3'b010, S2=3'b011, S3=3'b101.
- Counter: remaining is CNT_W bits. The maximum burst is 2**CNT_W-1 beats, and remaining never underflows.
- grant is one-hot or zero at all times.

Test Plan:
- Reset hold then release; req=0 -> all outputs 0, seq_data=3'b000; no grant for 10 cycles.
- req[1]=1, len1=6, seq_ready=1, RESTART=0 -> grant=4'b0010 1 cycle later; data 000,010,011,101,000,010; seq_last on beat 6; done=1 with done_id=1 on the next cycle; step pointer ends at S2.
- req=4'b1111, all len=2, ready=1 -> grant order 0,1,2,3,0; a 1-cycle IDLE gap between bursts; each burst shows exactly 2 beats.
- Backpressure: len0=3, seq_ready toggles 1,0,0,1,0,1 -> data held stable while ready=0; exactly 3 accepted beats 000,010,011; done after the third.
- len2=0 with req[2]=1, plus req[3]=1 with len3=1 -> requester 2 is never granted; requester 3 is granted for 1 beat with seq_last=1 on that beat.
- Reset asserted mid-burst on beat 2 of 5 -> next cycle grant=0, seq_valid=0, no done; the next burst starts at 3'b000 and requester 0 has priority.
